sar_seq_gate: RTL and testbench

- Parametrised successor to the static clock-gate cell bank.
- Generates the SAR control strobe sequence (init, sample, per-bit compare/update) itself from one system clock, then gates each strobe with shadowed enables.
- Sits between the digital config/control registers and the analog SAR core (DAC init switches, sampling switches, comparator, DAC update logic).
- Adds start/busy/done handshake, configurable sample length, bit count, continuous mode and abort.

---
 rtl/sar_seq_pkg.sv | 31 +++
 rtl/sar_seq_shadow.sv | 49 ++++
 rtl/sar_seq_gate.sv | 166 ++++++++++++++++
 tb/tb_sar_seq_gate.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_seq_pkg.sv
// Shared types for the SAR strobe sequencer: FSM state encoding, the strobe/enable
// bundle, and the conversion-length helper.
package sar_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SAMP,
    ST_COMP,
    ST_UPDATE,
    ST_DONE
  } state_e;

  // One bit per analog strobe; the same layout carries the enables and the gated outputs.
  typedef struct packed {
    logic init;
    logic samp_p;
    logic samp_n;
    logic comp;
    logic update;
  } strobe_t;

  // Cycles from the first INIT cycle through the DONE cycle, inclusive.
  function automatic int unsigned conv_len(input int unsigned num_bits,
                                           input int unsigned samp_len);
    int unsigned s;
    s = (samp_len == 0) ? 1 : samp_len;
    return 1 + s + 2 * num_bits + 1;
  endfunction

endpackage

// File: rtl/sar_seq_shadow.sv
// Shadow register bank: freezes strobe enables, sample length and continuous-mode
// request at the start of each conversion so mid-conversion config writes are ignored.
module sar_seq_shadow
  import sar_seq_pkg::*;
#(
  parameter int SAMP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_cont_i,
  input  strobe_t           en_i,
  input  logic [SAMP_W-1:0] samp_len_i,
  input  logic              cont_i,
  output strobe_t           en_o,
  output logic [SAMP_W-1:0] samp_len_o,
  output logic              cont_o
);

  strobe_t           en_q;
  logic [SAMP_W-1:0] samp_len_q;
  logic              cont_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= '0;
      samp_len_q <= '0;
      cont_q     <= 1'b0;
    end else begin
      if (load_i) begin
        en_q       <= en_i;
        samp_len_q <= samp_len_i;
      end
      // An abort must drop continuous mode even if it coincides with a reload.
      if (clr_cont_i) begin
        cont_q <= 1'b0;
      end else if (load_i) begin
        cont_q <= cont_i;
      end
    end
  end

  assign en_o       = en_q;
  assign samp_len_o = samp_len_q;
  assign cont_o     = cont_q;

endmodule

// File: rtl/sar_seq_gate.sv
// SAR control strobe sequencer: runs init / sample / per-bit compare-update phases
// from one clock and drives each phase strobe, gated by its shadowed enable, from a flop.
module sar_seq_gate
  import sar_seq_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int SAMP_W   = 8,
  parameter int IDX_W    = $clog2(NUM_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              stop,
  input  logic [SAMP_W-1:0] samp_len,
  input  logic              en_init,
  input  logic              en_samp_p,
  input  logic              en_samp_n,
  input  logic              en_comp,
  input  logic              en_update,
  output logic              clk_init,
  output logic              clk_samp_p,
  output logic              clk_samp_n,
  output logic              clk_comp,
  output logic              clk_update,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_BITS - 1);

  state_e            state_q, state_d;
  logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  strobe_t           strb_q, strb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  strobe_t           en_raw;
  strobe_t           en_sh;
  logic [SAMP_W-1:0] samp_len_sh;
  logic              cont_sh;
  logic              load;

  assign en_raw = '{init: en_init, samp_p: en_samp_p, samp_n: en_samp_n,
                    comp: en_comp, update: en_update};

  // INIT is only ever entered from IDLE or DONE, so entering it is the capture point.
  assign load = (state_d == ST_INIT);

  sar_seq_shadow #(
    .SAMP_W(SAMP_W)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .clr_cont_i(stop),
    .en_i      (en_raw),
    .samp_len_i(samp_len),
    .cont_i    (cont),
    .en_o      (en_sh),
    .samp_len_o(samp_len_sh),
    .cont_o    (cont_sh)
  );

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_INIT;
      end
      ST_INIT: begin
        state_d    = ST_SAMP;
        samp_cnt_d = (samp_len_sh == '0) ? '0 : samp_len_sh - SAMP_W'(1);
      end
      ST_SAMP: begin
        if (samp_cnt_q == '0) begin
          state_d   = ST_COMP;
          bit_idx_d = IDX_MAX;
        end else begin
          samp_cnt_d = samp_cnt_q - SAMP_W'(1);
        end
      end
      ST_COMP: begin
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (bit_idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_COMP;
          bit_idx_d = bit_idx_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (cont_sh) begin
          state_d = ST_INIT;
        end else begin
          state_d   = ST_IDLE;
          bit_idx_d = IDX_MAX;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_idx_d = IDX_MAX;
      end
    endcase

    if (stop) begin
      state_d   = ST_IDLE;
      bit_idx_d = IDX_MAX;
    end
  end

  // Strobes are decoded from the next state so they land in the same cycle as the phase.
  always_comb begin
    strb_d = '0;
    case (state_d)
      // The shadow captures on this same edge, so the INIT strobe takes the live enable.
      ST_INIT:   strb_d.init   = en_raw.init;
      ST_SAMP: begin
        strb_d.samp_p = en_sh.samp_p;
        strb_d.samp_n = en_sh.samp_n;
      end
      ST_COMP:   strb_d.comp   = en_sh.comp;
      ST_UPDATE: strb_d.update = en_sh.update;
      default:   strb_d        = '0;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      bit_idx_q  <= IDX_MAX;
      strb_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      strb_q     <= strb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign clk_init   = strb_q.init;
  assign clk_samp_p = strb_q.samp_p;
  assign clk_samp_n = strb_q.samp_n;
  assign clk_comp   = strb_q.comp;
  assign clk_update = strb_q.update;
  assign bit_idx    = bit_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sar_seq_gate.sv
// Scoreboard bench for sar_seq_gate (NUM_BITS=4): stimulus queues one expected
// output record per busy cycle; a monitor compares every cycle after the clock edge.
module tb_sar_seq_gate;

  localparam int NB = 4;
  localparam int SW = 8;
  localparam int IW = 2;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          cont     = 1'b0;
  logic          stop     = 1'b0;
  logic [SW-1:0] samp_len = '0;
  logic [4:0]    en_v     = '0;  // {init, samp_p, samp_n, comp, update}

  logic          clk_init, clk_samp_p, clk_samp_n, clk_comp, clk_update;
  logic [IW-1:0] bit_idx;
  logic          busy, done;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [7:0]    sb_q[$];
  logic [7:0]    exp_r;

  sar_seq_gate #(
    .NUM_BITS(NB),
    .SAMP_W  (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont      (cont),
    .stop      (stop),
    .samp_len  (samp_len),
    .en_init   (en_v[4]),
    .en_samp_p (en_v[3]),
    .en_samp_n (en_v[2]),
    .en_comp   (en_v[1]),
    .en_update (en_v[0]),
    .clk_init  (clk_init),
    .clk_samp_p(clk_samp_p),
    .clk_samp_n(clk_samp_n),
    .clk_comp  (clk_comp),
    .clk_update(clk_update),
    .bit_idx   (bit_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rec(input logic [4:0] s, input logic [IW-1:0] i, input logic d);
    return {s, i, d};
  endfunction

  // Expected record stream of one full conversion; idx_pre is bit_idx during INIT/SAMP.
  task automatic push_conv(input logic [4:0] en, input int s, input logic [IW-1:0] idx_pre);
    int se;
    se = (s == 0) ? 1 : s;
    sb_q.push_back(rec(en & 5'b10000, idx_pre, 1'b0));
    for (int k = 0; k < se; k++) sb_q.push_back(rec(en & 5'b01100, idx_pre, 1'b0));
    for (int b = NB - 1; b >= 0; b--) begin
      sb_q.push_back(rec(en & 5'b00010, IW'(b), 1'b0));
      sb_q.push_back(rec(en & 5'b00001, IW'(b), 1'b0));
    end
    sb_q.push_back(rec(5'b00000, '0, 1'b1));
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic start_conv(input logic [4:0] en, input logic [SW-1:0] sl, input logic c,
                            input logic [IW-1:0] idx_pre);
    en_v     = en;
    samp_len = sl;
    cont     = c;
    push_conv(en, int'(sl), idx_pre);
    pulse_start();
  endtask

  task automatic run_until_idle(input string name, input int exp);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      tick(1);
      n++;
    end
    check(name, n, exp);
  endtask

  // Monitor: one record per busy cycle, quiet outputs otherwise.
  always begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (busy) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", busy, 1'b0);
        end else begin
          exp_r = sb_q.pop_front();
          check("sb_cycle", {clk_init, clk_samp_p, clk_samp_n, clk_comp, clk_update,
                             bit_idx, done}, exp_r);
        end
      end else begin
        check("idle_quiet", {clk_init, clk_samp_p, clk_samp_n, clk_comp, clk_update, done}, 6'b0);
      end
    end
  end

  initial begin
    // Reset state
    tick(1);
    check("rst_outputs", {clk_init, clk_samp_p, clk_samp_n, clk_comp, clk_update, busy, done}, 7'b0);
    check("rst_bit_idx", bit_idx, 3);
    rst_n = 1'b1;
    tick(2);

    // 1: all enables, samp_len=3 -> 13 busy cycles, done in the last
    start_conv(5'b11111, 8'd3, 1'b0, 2'd3);
    run_until_idle("t1_len", 13);
    tick(2);

    // 2: samp_n and update disabled; a start while busy is ignored
    start_conv(5'b11010, 8'd3, 1'b0, 2'd3);
    tick(3);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    run_until_idle("t2_len", 9);
    tick(2);

    // 3: config change during SAMP only affects the following conversion
    start_conv(5'b11111, 8'd3, 1'b0, 2'd3);
    tick(1);
    en_v     = 5'b11101;
    samp_len = 8'd7;
    run_until_idle("t3_len_a", 12);
    tick(2);
    push_conv(5'b11101, 7, 2'd3);
    pulse_start();
    run_until_idle("t3_len_b", 17);
    tick(2);

    // 4: continuous mode with samp_len=0, three back-to-back conversions
    start_conv(5'b11111, 8'd0, 1'b1, 2'd3);
    push_conv(5'b11111, 0, 2'd0);
    push_conv(5'b11111, 0, 2'd0);
    tick(12);
    cont = 1'b0;
    run_until_idle("t4_len", 21);
    tick(2);

    // stop and start together in IDLE: stays idle
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    check("stop_start_idle", busy, 1'b0);
    tick(2);

    // 5: stop during the second COMP
    start_conv(5'b11111, 8'd3, 1'b0, 2'd3);
    tick(6);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_idx", bit_idx, 3);
    check("t5_sb_left", sb_q.size(), 6);
    sb_q.delete();
    tick(2);
    start_conv(5'b11111, 8'd3, 1'b0, 2'd3);
    run_until_idle("t5_len_b", 13);
    tick(2);

    // 6: async reset during UPDATE with bit_idx=2, start held across release
    start_conv(5'b11111, 8'd3, 1'b0, 2'd3);
    tick(7);
    check("t6_pre_idx", bit_idx, 2);
    check("t6_pre_upd", clk_update, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outputs", {clk_init, clk_samp_p, clk_samp_n, clk_comp, clk_update, busy, done}, 7'b0);
    check("t6_rst_idx", bit_idx, 3);
    check("t6_sb_left", sb_q.size(), 5);
    sb_q.delete();
    tick(2);
    rst_n = 1'b1;
    start_conv(5'b11111, 8'd3, 1'b0, 2'd3);
    run_until_idle("t6_len", 13);
    tick(2);

    // 7: maximum sample length must not wrap
    start_conv(5'b11111, 8'd255, 1'b0, 2'd3);
    run_until_idle("t7_len", 265);
    tick(3);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
